// File: rtl/multicycle_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One shift-add / restoring shift-subtract step per cycle; WIDTH+1 cycles per op.
module multicycle_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             CPU_RESET,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [1:0]       hilo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic               accept, iter_last;

    // acc holds {product high, product low} for multiply and {remainder, quotient} for divide
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               is_div, neg_q, neg_r;

    logic               div_op, sgn, div0, sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] div_next;

    logic [2*WIDTH-1:0] acc_neg;
    logic [WIDTH-1:0]   res_hi, res_lo;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (CPU_RESET) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (iter_last) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        accept    = (state == IDLE) && start;
        iter_last = (state == RUN) && (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (CPU_RESET)         cnt <= '0;
        else if (accept)       cnt <= '0;
        else if (state == RUN) cnt <= cnt + 1'b1;
    end

    // ---------------- operand capture ----------------
    // A zero divisor bypasses sign handling so the raw dividend falls out as the remainder
    // and the quotient saturates to all ones.
    always_comb begin
        div_op = op[1];
        sgn    = ~op[0];
        div0   = div_op && (src_b == '0);
        sa     = sgn && src_a[WIDTH-1] && !div0;
        sb     = sgn && src_b[WIDTH-1];
        mag_a  = sa ? -src_a : src_a;
        mag_b  = sb ? -src_b : src_b;
    end

    // ---------------- iteration datapath ----------------
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};

        div_sh   = acc[2*WIDTH-1:WIDTH-1];
        div_ge   = (div_sh >= {1'b0, opnd});
        div_diff = div_sh[WIDTH-1:0] - opnd;
        div_next = {(div_ge ? div_diff : div_sh[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
    end

    always_ff @(posedge clk) begin
        if (CPU_RESET) begin
            acc    <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else if (accept) begin
            acc    <= {{WIDTH{1'b0}}, (div_op ? mag_a : mag_b)};
            opnd   <= div_op ? mag_b : mag_a;
            is_div <= div_op;
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
        end else if (state == RUN) begin
            acc    <= is_div ? div_next : mul_next;
        end
    end

    // ---------------- sign fix-up ----------------
    always_comb begin
        acc_neg = -acc;
        if (!is_div) begin
            {res_hi, res_lo} = neg_q ? acc_neg : acc;
        end else begin
            res_lo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            res_hi = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end
    end

    // ---------------- HI/LO and done ----------------
    always_ff @(posedge clk) begin
        if (CPU_RESET) begin
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= (state == FIX);
            if (state == FIX) begin
                hi <= res_hi;
                lo <= res_lo;
            end else if (state == IDLE) begin
                if (hilo_we[1]) hi <= wdata;
                if (hilo_we[0]) lo <= wdata;
            end
        end
    end

endmodule

// File: doc/multicycle_muldiv.md
# multicycle_muldiv

Parametrised iterative multiply/divide unit for the multicycle core, the next-generation execution resource behind the main ALU. It executes MIPS-style MULT/MULTU/DIV/DIVU, one iteration per cycle, and holds results in architectural HI/LO registers with direct write ports for MTHI/MTLO. The control FSM drives it through a start/busy/done handshake and stalls on `busy`.

## Interface
- `WIDTH`, default 32: operand and HI/LO width; any value ≥ 4.
- `clk` in 1: single clock, all state updates on posedge.
- `CPU_RESET` in 1: synchronous, active-high reset.
- `start` in 1: request, sampled only when `busy`=0.
- `op` in 2: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `src_a` in WIDTH: multiplicand / dividend, sampled with `start`.
- `src_b` in WIDTH: multiplier / divisor, sampled with `start`.
- `hilo_we` in 2: bit1 writes HI, bit0 writes LO from `wdata`.
- `wdata` in WIDTH: MTHI/MTLO data.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse; HI/LO valid this cycle.
- `hi` out WIDTH: HI register (product upper half / remainder).
- `lo` out WIDTH: LO register (product lower half / quotient).

## Operation
- States: IDLE, RUN, FIX.
- IDLE: on `start`=1, latch operands, op and signs. Signed ops take magnitudes; the result signs are recorded. Clear iteration counter, go to RUN, `busy`=1.
- RUN: one iteration per cycle, exactly WIDTH iterations, then FIX.
  - Multiply: shift-add on magnitudes into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract on magnitudes.
- FIX: apply sign correction, write `hi`/`lo`, pulse `done`, clear `busy`, return to IDLE.
- Signed multiply: the product is negated when the operand signs differ. The result is the full 2·WIDTH two's-complement value {hi,lo}.
- Signed divide rules:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - MIN / −1 gives lo=MIN, hi=0 (wrap, no trap).
- Divide by zero, both DIV and DIVU: lo={WIDTH{1}}, hi=src_a as latched. The full latency still applies.
- `start` while `busy`=1 is ignored; no queueing.
- `hilo_we` is ignored while `busy`=1.
- `hilo_we` in IDLE writes the selected register(s) on the next edge. If it coincides with an accepted `start`, the write takes effect and the operation's result later overwrites both registers.
- `hi`/`lo` change only on a FIX edge, an accepted `hilo_we`, or reset. Outputs are held between operations.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, state IDLE, counter 0.
- Accept edge E0 (start=1 and busy=0). `busy`=1 from after E0 until after E(WIDTH+1).
- RUN covers edges E1..E(WIDTH).
- Edge E(WIDTH+1): FIX writes `hi`/`lo`; `done`=1 and `busy`=0 for exactly that one cycle.
- Latency: WIDTH+1 cycles from accept edge to `done`, independent of op and operand values.
- Back-to-back: a new `start` may be accepted in the `done` cycle (busy=0). Its `done` follows WIDTH+1 cycles later.
- `CPU_RESET` mid-operation: on the next edge return to IDLE, clear HI/LO, no `done` pulse. Reset overrides `start` and `hilo_we`.
- Operand inputs need to be stable only in the accept cycle.

## Test plan
- WIDTH=32, MULT src_a=0xFFFFFFFD (−3), src_b=7:
  - `busy` high for 33 cycles after the accept edge.
  - `done` on cycle 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU 0xFFFFFFFF×0xFFFFFFFF:
  - hi=0xFFFFFFFE, lo=0x00000001.
  - A second `start` raised on cycle 5 is ignored; exactly one `done`.
- DIV −7/2:
  - lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Then DIV 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0.
- DIVU 100/0:
  - lo=0xFFFFFFFF, hi=0x00000064, `done` still at cycle 33.
- `hilo_we`=11 with wdata=0x12345678 in IDLE: hi=lo=0x12345678.
  - During a running MULT, `hilo_we`=01 with 0xDEADBEEF has no effect.
  - Assert `CPU_RESET` at cycle 10 of the MULT: busy=0, hi=lo=0, no `done`.
- WIDTH=8, DIV 0x9C (−100) / 0x07:
  - `done` on cycle 9, lo=0xF2 (−14), hi=0xFE (−2).
  - Random MULTU/DIVU sweep checked against a behavioural model.
